divexec: RTL and testbench
==========================

Name: divexec

Overview:
- Iterative integer divide execution unit: the consumer end of the divider issue-queue interface.
- Accepts one ready instruction per handshake from the divide issue queue and computes the quotient over WIDTH cycles.
- Holds the result on a CDB request until the CDB arbiter grants it; the tagged result is then broadcast on the CDB.
- Single divider: one operation in flight; the queue stalls otherwise.

Parameters:
WIDTH, 32, operand/result width; also the iteration count.
TAG_W, 6, physical register tag width.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
issuediv_ready  input  1  queue holds a valid instruction with both operands resolved.
issuediv_rdtag  input  TAG_W  destination tag of the offered instruction.
issuediv_rsdata  input  WIDTH  dividend.
issuediv_rtdata  input  WIDTH  divisor.
issuediv_done  output  1  accept strobe; queue removes the offered entry at this clock edge.
divcdb_req  output  1  result valid, requesting a CDB slot.
divcdb_tag  output  TAG_W  result tag.
divcdb_data  output  WIDTH  quotient.
divcdb_grant  input  1  arbiter grants the CDB this cycle; result is consumed at this edge.

Behaviour:
- States: IDLE, BUSY, DONE. Reset (reset=0, asynchronous) forces IDLE, count=0, all datapath registers=0, divcdb_req=0, divcdb_tag=0, divcdb_data=0. An in-flight operation is discarded with no CDB output.
- issuediv_done is combinational: issuediv_ready & (IDLE | (DONE & divcdb_grant)). It never asserts while issuediv_ready=0 or during BUSY.
- Accept edge (issuediv_done=1):
  - Capture rdtag.
  - Load remainder=0, quotient register = |dividend|, divisor register = |divisor|.
  - Record the quotient sign (dividend sign XOR divisor sign) and a divide-by-zero flag (divisor==0).
  - count=WIDTH; go to BUSY.
- BUSY: one restoring-division step per cycle.
  - Shift {rem,quo} left by 1.
  - Trial subtract the divisor from rem. If non-negative, keep the difference and set quo LSB=1; else restore.
  - Decrement count. The edge where count goes 1->0 enters DONE.
- DONE: divcdb_req=1; tag and data are stable until the grant edge.
  - Data is the quotient negated if the sign is set.
  - Divide-by-zero: data = all ones (32'hFFFFFFFF), regardless of sign.
  - Overflow case (-2^WIDTH-1 / -1): result 0x80000000, the natural wrap.
  - On divcdb_grant: if issuediv_ready, accept the new instruction at the same edge (back-to-back) and go to BUSY; else go to IDLE.
- Latency: accept edge t0 -> divcdb_req high in the cycle after edge t0+WIDTH. Minimum initiation interval is WIDTH+1 cycles with immediate grant.
- divcdb_grant is ignored when divcdb_req=0.
- A grant never arrives in the same cycle the request first rises unless the arbiter is combinational; either case is legal.
- Issue-side operand values are sampled only on the accept edge. Later changes on issuediv_* have no effect.

Optional Feature:
DIVEXEC_SIGNED_EN
- Defined: operands are two's-complement (MIPS DIV), with sign handling as above.
- Undefined: unsigned division (DIVU). Magnitude conversion and result negation are removed. Divide-by-zero still returns all ones.

Test Plan:
- Unsigned: reset released, issuediv_ready=1, rs=100, rt=7, tag=5 -> issuediv_done pulses 1 cycle, divcdb_req rises 33 cycles later with tag=5, data=14; grant -> req drops next cycle, IDLE.
- Signed (DIVEXEC_SIGNED_EN): rs=0xFFFFFF9C, rt=7 -> data=0xFFFFFFF2. Without the macro, same stimulus -> data=0x24924916.
- Divide by zero: rs=1234, rt=0, tag=9 -> after 33 cycles req=1, tag=9, data=0xFFFFFFFF.
- Grant stall and back-to-back: hold grant=0 for 5 cycles -> req/tag/data stable and issuediv_done=0 despite issuediv_ready=1. Then grant=1 with a second instruction pending -> issuediv_done=1 in the grant cycle, next result arrives 33 cycles later.
- Reset mid-operation: assert reset=0 at iteration 10, asynchronously between edges -> req/tag/data go 0 immediately. After release, no stale result appears, and a new op 50/5 returns 10.
- Signed overflow: rs=0x80000000, rt=0xFFFFFFFF -> data=0x80000000, no hang, returns to IDLE after grant.

Source files
------------

// File: rtl/divexec_if.sv
// Issue-queue / CDB handshake bundle for the divexec divide unit.
// Modport "slave" is the divider's view; "master" is the environment (queue + arbiter).
interface divexec_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
);
    logic             issuediv_ready;
    logic [TAG_W-1:0] issuediv_rdtag;
    logic [WIDTH-1:0] issuediv_rsdata;
    logic [WIDTH-1:0] issuediv_rtdata;
    logic             issuediv_done;
    logic             divcdb_req;
    logic [TAG_W-1:0] divcdb_tag;
    logic [WIDTH-1:0] divcdb_data;
    logic             divcdb_grant;

    modport slave (
        input  issuediv_ready, issuediv_rdtag, issuediv_rsdata, issuediv_rtdata, divcdb_grant,
        output issuediv_done, divcdb_req, divcdb_tag, divcdb_data
    );

    modport master (
        output issuediv_ready, issuediv_rdtag, issuediv_rsdata, issuediv_rtdata, divcdb_grant,
        input  issuediv_done, divcdb_req, divcdb_tag, divcdb_data
    );
endinterface

// File: rtl/divexec.sv
// Iterative restoring divider: accepts one op from the divide issue queue, holds the tagged quotient on the CDB until granted.
// Define DIVEXEC_SIGNED_EN for two's-complement (DIV); default build is unsigned (DIVU).
module divexec #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    divexec_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
    logic [TAG_W-1:0] r_tag;
    logic             r_neg, r_dz;

    logic             w_accept;
    logic [WIDTH-1:0] w_mag_rs, w_mag_rt;
    logic             w_sign;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx, w_result;

`ifdef DIVEXEC_SIGNED_EN
    always_comb begin
        w_mag_rs = bus.issuediv_rsdata[WIDTH-1] ? -bus.issuediv_rsdata : bus.issuediv_rsdata;
        w_mag_rt = bus.issuediv_rtdata[WIDTH-1] ? -bus.issuediv_rtdata : bus.issuediv_rtdata;
        w_sign   = bus.issuediv_rsdata[WIDTH-1] ^ bus.issuediv_rtdata[WIDTH-1];
    end
`else
    always_comb begin
        w_mag_rs = bus.issuediv_rsdata;
        w_mag_rt = bus.issuediv_rtdata;
        w_sign   = 1'b0;
    end
`endif

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor from the widened remainder.
    always_comb begin
        w_rem_sh = {r_rem, r_quo[WIDTH-1]};
        w_ge     = w_rem_sh >= {1'b0, r_dvs};
        w_rem_nx = w_ge ? (w_rem_sh[WIDTH-1:0] - r_dvs) : w_rem_sh[WIDTH-1:0];
        w_result = r_dz ? '1 : (r_neg ? -r_quo : r_quo);
    end

    always_comb begin
        w_accept = bus.issuediv_ready &
                   ((r_state == IDLE) | ((r_state == DONE) & bus.divcdb_grant));
        w_next   = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = BUSY;
            BUSY:    if (r_count == CNT_W'(1)) w_next = DONE;
            DONE:    if (bus.divcdb_grant) w_next = w_accept ? BUSY : IDLE;
            default: w_next = IDLE;
        endcase
        bus.issuediv_done = w_accept;
        bus.divcdb_req    = (r_state == DONE);
        bus.divcdb_tag    = (r_state == DONE) ? r_tag : '0;
        bus.divcdb_data   = (r_state == DONE) ? w_result : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_tag   <= '0;
            r_neg   <= 1'b0;
            r_dz    <= 1'b0;
        end else if (w_accept) begin
            r_count <= CNT_W'(WIDTH);
            r_rem   <= '0;
            r_quo   <= w_mag_rs;
            r_dvs   <= w_mag_rt;
            r_tag   <= bus.issuediv_rdtag;
            r_neg   <= w_sign;
            r_dz    <= (bus.issuediv_rtdata == '0);
        end else if (r_state == BUSY) begin
            r_count <= r_count - 1'b1;
            r_rem   <= w_rem_nx;
            r_quo   <= {r_quo[WIDTH-2:0], w_ge};
        end
    end
endmodule

// File: tb/tb_divexec.sv
// Directed-vector bench for divexec: hand-computed quotients, latency, grant stall, back-to-back and async reset.
module tb_divexec;
    localparam int WIDTH = 32;
    localparam int TAG_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    divexec_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    divexec #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] rs, input logic [31:0] rt, input logic [5:0] tag);
        @(negedge clk);
        bus.issuediv_ready  = 1'b1;
        bus.issuediv_rsdata = rs;
        bus.issuediv_rtdata = rt;
        bus.issuediv_rdtag  = tag;
        #1 check("done_on_accept", 32'(bus.issuediv_done), 32'd1);
        @(posedge clk);
        #1 check("done_low_busy", 32'(bus.issuediv_done), 32'd0);
        bus.issuediv_ready  = 1'b0;
        bus.issuediv_rsdata = $urandom;
        bus.issuediv_rtdata = $urandom;
        bus.issuediv_rdtag  = 6'h3F;
    endtask

    // Call #1 after the accept edge; counts edges until req rises.
    task automatic wait_result(input string name, input logic [5:0] tag, input logic [31:0] data);
        int lat = 0;
        while (bus.divcdb_req !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(WIDTH));
        check({name, "_tag"}, 32'(bus.divcdb_tag), 32'(tag));
        check({name, "_data"}, bus.divcdb_data, data);
    endtask

    task automatic grant_and_drop(input string name);
        @(negedge clk);
        bus.divcdb_grant = 1'b1;
        @(posedge clk);
        #1 bus.divcdb_grant = 1'b0;
        check({name, "_req_drop"}, 32'(bus.divcdb_req), 32'd0);
    endtask

    initial begin
        int stale;
        logic [31:0] exp_neg, exp_ovf;
`ifdef DIVEXEC_SIGNED_EN
        exp_neg = 32'hFFFFFFF2;
        exp_ovf = 32'h80000000;
`else
        exp_neg = 32'h24924916;
        exp_ovf = 32'h00000000;
`endif
        bus.issuediv_ready  = 1'b0;
        bus.issuediv_rdtag  = '0;
        bus.issuediv_rsdata = '0;
        bus.issuediv_rtdata = '0;
        bus.divcdb_grant    = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus.divcdb_req), 32'd0);
        check("rst_tag", 32'(bus.divcdb_tag), 32'd0);
        check("rst_data", bus.divcdb_data, 32'd0);
        check("rst_done", 32'(bus.issuediv_done), 32'd0);
        reset = 1'b1;

        issue(32'd100, 32'd7, 6'd5);
        wait_result("u100_7", 6'd5, 32'd14);
        grant_and_drop("u100_7");

        issue(32'hFFFFFF9C, 32'd7, 6'd3);
        wait_result("neg100_7", 6'd3, exp_neg);
        grant_and_drop("neg100_7");

        issue(32'd1234, 32'd0, 6'd9);
        wait_result("divzero", 6'd9, 32'hFFFFFFFF);
        grant_and_drop("divzero");

        issue(32'hFFFFFFFF, 32'd1, 6'd63);
        wait_result("allones_1", 6'd63, 32'hFFFFFFFF);
        grant_and_drop("allones_1");

        // Grant stall with a second op pending, then back-to-back accept on the grant edge.
        issue(32'd1000, 32'd10, 6'd12);
        wait_result("stall", 6'd12, 32'd100);
        @(negedge clk);
        bus.issuediv_ready  = 1'b1;
        bus.issuediv_rsdata = 32'd77;
        bus.issuediv_rtdata = 32'd7;
        bus.issuediv_rdtag  = 6'd20;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_req", 32'(bus.divcdb_req), 32'd1);
            check("stall_tag", 32'(bus.divcdb_tag), 32'd12);
            check("stall_data", bus.divcdb_data, 32'd100);
            check("stall_done", 32'(bus.issuediv_done), 32'd0);
            @(negedge clk);
        end
        bus.divcdb_grant = 1'b1;
        #1 check("b2b_done", 32'(bus.issuediv_done), 32'd1);
        @(posedge clk);
        #1 bus.divcdb_grant = 1'b0;
        bus.issuediv_ready  = 1'b0;
        bus.issuediv_rsdata = 32'd5;
        bus.issuediv_rtdata = 32'd5;
        check("b2b_req_drop", 32'(bus.divcdb_req), 32'd0);
        wait_result("b2b", 6'd20, 32'd11);
        grant_and_drop("b2b");

        // Async reset while a result is held on the CDB.
        issue(32'd81, 32'd9, 6'd17);
        wait_result("held", 6'd17, 32'd9);
        #3 reset = 1'b0;
        #1;
        check("arst_req", 32'(bus.divcdb_req), 32'd0);
        check("arst_tag", 32'(bus.divcdb_tag), 32'd0);
        check("arst_data", bus.divcdb_data, 32'd0);
        @(negedge clk) reset = 1'b1;

        // Async reset mid-iteration: no stale result afterwards.
        issue(32'd999, 32'd3, 6'd7);
        repeat (9) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("midop_req", 32'(bus.divcdb_req), 32'd0);
        @(negedge clk) reset = 1'b1;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.divcdb_req !== 1'b0) stale++;
        end
        check("no_stale", 32'(stale), 32'd0);

        issue(32'd50, 32'd5, 6'd4);
        wait_result("post_rst", 6'd4, 32'd10);
        grant_and_drop("post_rst");

        issue(32'h80000000, 32'hFFFFFFFF, 6'd33);
        wait_result("ovf", 6'd33, exp_ovf);
        grant_and_drop("ovf");
        @(negedge clk);
        bus.issuediv_ready = 1'b1;
        #1 check("idle_accept", 32'(bus.issuediv_done), 32'd1);
        bus.issuediv_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
